// File: rtl/wshb_arbiter2_if.sv
// Wishbone bus bundle; master drives the request side, slave drives the response side.
interface wshb_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   adr;
  logic [DW/8-1:0] sel;
  logic [DW-1:0]   dat_ms;
  logic [DW-1:0]   dat_sm;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic            ack;
  logic            err;
  logic            rty;

  modport master (output cyc, stb, we, adr, sel, dat_ms, cti, bte,
                  input  dat_sm, ack, err, rty);
  modport slave  (input  cyc, stb, we, adr, sel, dat_ms, cti, bte,
                  output dat_sm, ack, err, rty);
endinterface

// File: rtl/wshb_arbiter2.sv
// Two-master round-robin Wishbone arbiter with cycle-granular locking and an
// access watchdog that terminates a hung slave with err.
module wshb_arbiter2 #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  wshb_if.slave      m0,
  wshb_if.slave      m1,
  wshb_if.master     s,
  output logic [1:0] grant,
  output logic       tmo_evt
);

  // State encoding doubles as the one-hot grant, so grant is a direct register.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] OWN0 = 2'b01;
  localparam logic [1:0] OWN1 = 2'b10;

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        rr_last;
  logic        rr_last_nxt;
  logic [15:0] wd_cnt;
  logic        own0;
  logic        own1;
  logic        stb_raw;
  logic        term;
  logic        expire;

  assign grant = state;
  assign own0  = (state == OWN0);
  assign own1  = (state == OWN1);

  always_comb begin
    state_nxt   = state;
    rr_last_nxt = rr_last;
    case (state)
      IDLE: begin
        if (m0.cyc && m1.cyc) state_nxt = rr_last ? OWN0 : OWN1;
        else if (m0.cyc)      state_nxt = OWN0;
        else if (m1.cyc)      state_nxt = OWN1;
      end
      OWN0: begin
        if (!m0.cyc) begin
          rr_last_nxt = 1'b0;
          state_nxt   = m1.cyc ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!m1.cyc) begin
          rr_last_nxt = 1'b1;
          state_nxt   = m0.cyc ? OWN0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rr_last <= 1'b1;
    end else begin
      state   <= state_nxt;
      rr_last <= rr_last_nxt;
    end
  end

  // Watchdog: a slave termination in the expiry cycle wins over the forced err.
  assign stb_raw = (own0 & m0.stb) | (own1 & m1.stb);
  assign term    = s.ack | s.err | s.rty;
  assign expire  = (TIMEOUT != 0) && stb_raw && !term && (wd_cnt == TMO_LIMIT);
  assign tmo_evt = expire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       wd_cnt <= '0;
    else if (TIMEOUT == 0 || !stb_raw || term || expire) wd_cnt <= '0;
    else                                            wd_cnt <= wd_cnt + 16'd1;
  end

  assign s.cyc    = (own0 & m0.cyc) | (own1 & m1.cyc);
  assign s.stb    = stb_raw & ~expire;
  assign s.we     = (own0 & m0.we) | (own1 & m1.we);
  assign s.adr    = own0 ? m0.adr    : own1 ? m1.adr    : '0;
  assign s.sel    = own0 ? m0.sel    : own1 ? m1.sel    : '0;
  assign s.dat_ms = own0 ? m0.dat_ms : own1 ? m1.dat_ms : '0;
  assign s.cti    = own0 ? m0.cti    : own1 ? m1.cti    : '0;
  assign s.bte    = own0 ? m0.bte    : own1 ? m1.bte    : '0;

  assign m0.ack    = own0 & s.ack;
  assign m0.err    = own0 & (s.err | expire);
  assign m0.rty    = own0 & s.rty;
  assign m0.dat_sm = s.dat_sm;

  assign m1.ack    = own1 & s.ack;
  assign m1.err    = own1 & (s.err | expire);
  assign m1.rty    = own1 & s.rty;
  assign m1.dat_sm = s.dat_sm;

endmodule

// File: tb/tb_wshb_arbiter2.sv
// Randomized and directed bench for wshb_arbiter2 against an owner-level reference model.
module tb_wshb_arbiter2;

  localparam int unsigned TMO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       tmo_evt;

  wshb_if m0_bus ();
  wshb_if m1_bus ();
  wshb_if s_bus ();

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current owner (-1 none), last owner, cycles stb has waited.
  int mdl_owner;
  bit mdl_last;
  int mdl_wait;

  always #5 clk = ~clk;

  wshb_arbiter2 #(.TIMEOUT(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .m0      (m0_bus.slave),
    .m1      (m1_bus.slave),
    .s       (s_bus.master),
    .grant   (grant),
    .tmo_evt (tmo_evt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_m(input int idx, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic [2:0] cti, input logic [1:0] bte);
    if (idx == 0) begin
      m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we; m0_bus.adr = adr;
      m0_bus.dat_ms = dat; m0_bus.sel = sel; m0_bus.cti = cti; m0_bus.bte = bte;
    end else begin
      m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we; m1_bus.adr = adr;
      m1_bus.dat_ms = dat; m1_bus.sel = sel; m1_bus.cti = cti; m1_bus.bte = bte;
    end
  endtask

  task automatic drive_s(input logic ack, input logic err, input logic rty, input logic [31:0] dat);
    s_bus.ack = ack; s_bus.err = err; s_bus.rty = rty; s_bus.dat_sm = dat;
  endtask

  task automatic idle_all();
    drive_m(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'h0, 2'h0);
    drive_m(1, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'h0, 2'h0);
    drive_s(0, 0, 0, 32'h0);
  endtask

  task automatic model_reset();
    mdl_owner = -1;
    mdl_last  = 1'b1;
    mdl_wait  = 0;
  endtask

  // Compares every DUT output at the falling edge, then advances the model.
  task automatic check_model();
    logic        raw, trm, fire, ecyc, other_cyc;
    logic [1:0]  eg;
    logic [41:0] ectl;
    logic [31:0] edat;
    int          other;
    @(negedge clk);
    case (mdl_owner)
      0: begin
        eg = 2'b01; raw = m0_bus.stb; ecyc = m0_bus.cyc; edat = m0_bus.dat_ms;
        ectl = {m0_bus.we, m0_bus.sel, m0_bus.cti, m0_bus.bte, m0_bus.adr};
      end
      1: begin
        eg = 2'b10; raw = m1_bus.stb; ecyc = m1_bus.cyc; edat = m1_bus.dat_ms;
        ectl = {m1_bus.we, m1_bus.sel, m1_bus.cti, m1_bus.bte, m1_bus.adr};
      end
      default: begin
        eg = 2'b00; raw = 1'b0; ecyc = 1'b0; edat = 32'h0; ectl = 42'h0;
      end
    endcase
    trm  = s_bus.ack | s_bus.err | s_bus.rty;
    fire = raw && !trm && (mdl_wait == int'(TMO));

    check_eq("grant", 64'(grant), 64'(eg));
    check_eq("s_cyc", 64'(s_bus.cyc), 64'(ecyc));
    check_eq("s_stb", 64'(s_bus.stb), 64'(raw & ~fire));
    check_eq("s_ctl", 64'({s_bus.we, s_bus.sel, s_bus.cti, s_bus.bte, s_bus.adr}), 64'(ectl));
    check_eq("s_dat", 64'(s_bus.dat_ms), 64'(edat));
    check_eq("m0_resp", 64'({m0_bus.ack, m0_bus.err, m0_bus.rty}),
             (mdl_owner == 0) ? 64'({s_bus.ack, s_bus.err | fire, s_bus.rty}) : 64'h0);
    check_eq("m1_resp", 64'({m1_bus.ack, m1_bus.err, m1_bus.rty}),
             (mdl_owner == 1) ? 64'({s_bus.ack, s_bus.err | fire, s_bus.rty}) : 64'h0);
    check_eq("m0_dat", 64'(m0_bus.dat_sm), 64'(s_bus.dat_sm));
    check_eq("m1_dat", 64'(m1_bus.dat_sm), 64'(s_bus.dat_sm));
    check_eq("tmo_evt", 64'(tmo_evt), 64'(fire));

    mdl_wait = (!raw || trm || fire) ? 0 : mdl_wait + 1;
    if (mdl_owner < 0) begin
      if (m0_bus.cyc && m1_bus.cyc) mdl_owner = 1 - int'(mdl_last);
      else if (m0_bus.cyc)          mdl_owner = 0;
      else if (m1_bus.cyc)          mdl_owner = 1;
    end else if (!((mdl_owner == 0) ? m0_bus.cyc : m1_bus.cyc)) begin
      mdl_last  = (mdl_owner == 1);
      other     = 1 - mdl_owner;
      other_cyc = (other == 0) ? m0_bus.cyc : m1_bus.cyc;
      mdl_owner = other_cyc ? other : -1;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycle();
    check_model();
    next_cycle();
  endtask

  initial begin
    int         held [2];
    logic [1:0] prev_g, want;
    int         n_own;
    logic       r;
    logic       rc [2];
    logic       stb;
    int         ack_div;

    // Reset with every input active: outputs must still be quiet.
    rst = 1'b0;
    drive_m(0, 1, 1, 1, 32'hDEAD_BEEF, 32'h1234_5678, 4'hF, 3'h2, 2'h1);
    drive_m(1, 1, 1, 1, 32'hCAFE_F00D, 32'h8765_4321, 4'hF, 3'h2, 2'h1);
    drive_s(1, 1, 1, 32'h5555_AAAA);
    #2;
    check_eq("rst_grant", 64'(grant), 64'h0);
    check_eq("rst_s_cyc_stb", 64'({s_bus.cyc, s_bus.stb}), 64'h0);
    check_eq("rst_s_ctl", 64'({s_bus.we, s_bus.sel, s_bus.cti, s_bus.bte, s_bus.adr}), 64'h0);
    check_eq("rst_s_dat", 64'(s_bus.dat_ms), 64'h0);
    check_eq("rst_m0_resp", 64'({m0_bus.ack, m0_bus.err, m0_bus.rty}), 64'h0);
    check_eq("rst_m1_resp", 64'({m1_bus.ack, m1_bus.err, m1_bus.rty}), 64'h0);
    check_eq("rst_tmo", 64'(tmo_evt), 64'h0);
    next_cycle();
    idle_all();
    model_reset();
    rst = 1'b1;
    run_cycle();

    // Single owner: four acked reads from 0x100.
    drive_m(0, 1, 1, 0, 32'h100, 32'h0, 4'hF, 3'h0, 2'h0);
    check_model();
    check_eq("t1_no_grant_yet", 64'(grant), 64'h0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      drive_s(1, 0, 0, 32'hA5A5_0000 + 32'(i));
      check_model();
      check_eq("t1_grant", 64'(grant), 64'h1);
      check_eq("t1_ack", 64'(m0_bus.ack), 64'h1);
      check_eq("t1_data", 64'(m0_bus.dat_sm), 64'(32'hA5A5_0000 + 32'(i)));
      check_eq("t1_m1_ack", 64'(m1_bus.ack), 64'h0);
      check_eq("t1_adr", 64'(s_bus.adr), 64'h100);
      next_cycle();
    end
    idle_all();
    run_cycle();
    run_cycle();

    // Simultaneous request right after a fresh reset.
    rst = 1'b0;
    #1;
    check_eq("t2_rst_grant", 64'(grant), 64'h0);
    model_reset();
    next_cycle();
    rst = 1'b1;
    drive_m(0, 1, 0, 0, 32'h10, 32'h0, 4'hF, 3'h0, 2'h0);
    drive_m(1, 1, 0, 1, 32'h20, 32'h0, 4'hF, 3'h0, 2'h0);
    run_cycle();
    check_model();
    check_eq("t2_first_m0", 64'(grant), 64'h1);
    next_cycle();
    run_cycle();
    drive_m(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'h0, 2'h0);
    run_cycle();
    check_model();
    check_eq("t2_handoff", 64'(grant), 64'h2);
    next_cycle();
    idle_all();
    run_cycle();
    run_cycle();

    // Fairness: both masters keep coming back after two acked accesses each.
    held[0] = 0; held[1] = 0;
    prev_g = 2'b00; want = 2'b01; n_own = 0;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < 2; i++) begin
        r = 1'b1;
        if (mdl_owner == i) begin
          held[i]++;
          if (held[i] > 2) begin
            r = 1'b0;
            held[i] = 0;
          end
        end
        drive_m(i, r, r, 1, 32'h200 + 32'(i), 32'(c), 4'hF, 3'h0, 2'h0);
      end
      drive_s(1, 0, 0, 32'(c));
      check_model();
      if (grant != 2'b00 && grant != prev_g && n_own < 8) begin
        check_eq("t3_rr", 64'(grant), 64'(want));
        want = ~want;
        n_own++;
      end
      prev_g = grant;
      next_cycle();
    end
    check_eq("t3_periods", 64'(n_own), 64'd8);
    idle_all();
    run_cycle();
    run_cycle();

    // Watchdog: m1 strobes into a silent slave.
    drive_m(1, 1, 0, 1, 32'h300, 32'h77, 4'hF, 3'h0, 2'h0);
    run_cycle();
    run_cycle();
    drive_m(1, 1, 1, 1, 32'h300, 32'h77, 4'hF, 3'h0, 2'h0);
    for (int j = 0; j <= 10; j++) begin
      check_model();
      check_eq("t4_err", 64'(m1_bus.err), 64'(j == 8));
      check_eq("t4_tmo", 64'(tmo_evt), 64'(j == 8));
      check_eq("t4_stb", 64'(s_bus.stb), 64'(j != 8));
      check_eq("t4_grant", 64'(grant), 64'h2);
      next_cycle();
    end

    // Ack arriving in the expiry cycle wins.
    drive_m(1, 1, 0, 1, 32'h300, 32'h77, 4'hF, 3'h0, 2'h0);
    run_cycle();
    drive_m(1, 1, 1, 1, 32'h304, 32'h78, 4'hF, 3'h0, 2'h0);
    for (int j = 0; j <= 8; j++) begin
      drive_s(logic'(j == 8), 0, 0, 32'h5A5A_0000);
      check_model();
      if (j == 8) begin
        check_eq("t5_ack", 64'(m1_bus.ack), 64'h1);
        check_eq("t5_err", 64'(m1_bus.err), 64'h0);
        check_eq("t5_tmo", 64'(tmo_evt), 64'h0);
      end
      next_cycle();
    end
    idle_all();
    run_cycle();
    run_cycle();

    // Reset while m0 owns with stb high.
    drive_m(0, 1, 1, 0, 32'h400, 32'h0, 4'hF, 3'h0, 2'h0);
    run_cycle();
    run_cycle();
    rst = 1'b0;
    #1;
    check_eq("t6_s_cyc", 64'(s_bus.cyc), 64'h0);
    check_eq("t6_s_stb", 64'(s_bus.stb), 64'h0);
    check_eq("t6_grant", 64'(grant), 64'h0);
    model_reset();
    drive_m(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'h0, 2'h0);
    next_cycle();
    rst = 1'b1;
    drive_m(1, 1, 1, 1, 32'h500, 32'h9, 4'hF, 3'h0, 2'h0);
    check_model();
    check_eq("t6_wait", 64'(grant), 64'h0);
    next_cycle();
    check_model();
    check_eq("t6_m1_grant", 64'(grant), 64'h2);
    next_cycle();
    idle_all();
    run_cycle();

    // Randomized traffic, alternating responsive and sluggish slave phases.
    rc[0] = 1'b0; rc[1] = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(7) == 0) rc[i] = ~rc[i];
        stb = rc[i] & ($urandom_range(3) != 0);
        drive_m(i, rc[i], stb, 1'($urandom), $urandom, $urandom, 4'($urandom),
                3'($urandom), 2'($urandom));
      end
      ack_div = ((c / 200) % 2 == 1) ? 15 : 2;
      drive_s(logic'($urandom_range(ack_div) == 0), logic'($urandom_range(31) == 0),
              logic'($urandom_range(31) == 0), $urandom);
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wshb_arbiter2.md
Name: wshb_arbiter2

Overview:
- Two-master, one-slave Wishbone arbiter for the graphics controller.
- Shares the single framebuffer/SDRAM Wishbone slave port between the video read path (m0, display refill) and the pattern/write path (m1).
- Uses round-robin grant with cycle-granular locking: a grant is held for the whole cyc assertion.
- Contains a per-access watchdog that terminates a hung slave access with err.

Parameters:
- TIMEOUT, 255, max cycles s.stb may stay high without ack/err/rty before the arbiter forces err; 0 disables the watchdog; legal range 0..65535.

Ports:
- clk, input, 1, system clock; all state updates on posedge.
- rst, input, 1, asynchronous, active-low reset.
- m0, wshb_if.slave modport, interface, master 0 (video reader) side.
- m1, wshb_if.slave modport, interface, master 1 (writer) side.
- s, wshb_if.master modport, interface, shared slave side.
- grant, output, 2, one-hot current owner: bit0 = m0, bit1 = m1, 00 = none.
- tmo_evt, output, 1, one-cycle pulse when the watchdog fires.

Behaviour:
- FSM states: IDLE, OWN0, OWN1. grant is decoded from state and is registered.
- Round-robin pointer rr_last (1 bit) records the last owner. Reset value is 1, so m0 wins the first tie.
- Reset (rst=0, asynchronous):
  - state = IDLE, grant = 00, rr_last = 1, watchdog counter = 0, tmo_evt = 0.
  - s.cyc = s.stb = s.we = 0; s.adr, s.dat_ms, s.sel, s.cti, s.bte = 0.
  - m0/m1 ack, err, rty = 0.
  - A reset asserted mid-access drops s.cyc/s.stb in the same instant, without waiting for a clock edge.
- IDLE:
  - m0.cyc only -> OWN0; m1.cyc only -> OWN1.
  - Both requesting -> the master that is not rr_last.
  - Neither requesting -> stay in IDLE.
- OWNx:
  - Stay while mx.cyc = 1; the grant is never revoked mid-cycle.
  - mx.cyc = 0 and the other master's cyc = 1 -> go directly to the other OWN (no IDLE bubble).
  - mx.cyc = 0 and no other request -> IDLE.
  - On leaving OWNx, rr_last = x.
- Latency: a request whose cyc rises in cycle N sees s.cyc = 1 in cycle N+1 (one registered grant stage). The handoff gap between owners is 1 cycle.
- Datapath, purely combinational from the registered grant:
  - s.{cyc, stb, we, adr, sel, dat_ms, cti, bte} = owner's signals; all 0 when no owner.
  - owner.{ack, err, rty} = s.{ack, err, rty}.
  - Non-owner ack/err/rty = 0.
  - s.dat_sm is broadcast to both m0.dat_sm and m1.dat_sm.
- A non-owner may hold cyc/stb indefinitely. It sees no ack until it is granted.
- Watchdog:
  - 16-bit counter; clears whenever s.stb = 0 or any of s.ack/err/rty = 1; otherwise increments each cycle while s.stb = 1.
  - When the count reaches TIMEOUT with no termination:
    - owner.err = 1 for exactly that cycle;
    - tmo_evt = 1 for that cycle;
    - s.stb is forced to 0 for that cycle;
    - the counter clears.
  - A slave ack arriving in the same cycle as expiry takes precedence: the ack is passed through, with no err and no tmo_evt.
  - The forced err does not release the grant; the owner decides whether to drop cyc.
- Pipelined/burst accesses (cti = 010) pass transparently; the arbiter does not inspect cti/bte.

Test Plan:
- Single owner: after reset, m0 drives cyc/stb with adr=0x100 for 4 acked reads, slave returns 0xA5A5_0000+i. Required: grant = 01 from the cycle after m0.cyc rises; m0 receives 4 acks and data 0xA5A50000..03; m1 ack = 0; s.adr = 0x100.
- Simultaneous request right after reset: m0.cyc and m1.cyc both rise in the same cycle. Required: m0 is granted first; when m0 drops cyc, grant = 10 on the next cycle with no IDLE cycle; rr_last = 0.
- Fairness: both masters continuously re-request, each cycle 2 accesses long. Required: grant alternates 01, 10, 01, 10 over 8 cycles of ownership; neither master is granted twice in a row.
- Watchdog: TIMEOUT = 8; m1 owns, stb = 1, slave never acks. Required: m1.err = 1 and tmo_evt = 1 exactly 8 cycles after stb rises; s.stb = 0 in that cycle; grant stays 10 while m1.cyc = 1.
- Ack at expiry: TIMEOUT = 8; slave acks on the 8th cycle. Required: m1.ack = 1, m1.err = 0, tmo_evt = 0.
- Reset mid-access: assert rst low while m0 owns with stb = 1. Required: s.cyc = s.stb = 0 and grant = 00 before the next posedge; after release with only m1 requesting, m1 is granted on the cycle after its cyc rises.
